csr_irq_unit: RTL and testbench
===============================

# csr_irq_unit

Machine-mode CSR file and interrupt controller for the RV32 core, the parametrised successor of the current single-external/single-timer CSR block. Sits beside the execute stage: it serves Zicsr reads and writes and counts cycles and retired instructions. It arbitrates `NUM_LOCAL` platform interrupts plus MEI/MSI/MTI, and generates trap-entry and `mret` redirect PCs, including WFI sleep/wake.

## Interface
- `NUM_LOCAL`, default 4: platform interrupt lines mapped to mip/mie bits 16 .. 16+NUM_LOCAL-1; legal range 0..16.
- `MTVEC_RST`, default 32'h0000_0288: reset value of mtvec.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: pipeline stall; blocks all architectural updates except mcycle.
- `csr_valid` in 1: Zicsr instruction in execute.
- `csr_addr` in 12: CSR address.
- `csr_funct3` in 3: Zicsr op (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- `csr_rs1_idx` in 5: rs1 index, which is also uimm.
- `csr_rs1_data` in 32: rs1 value.
- `csr_rdata` out 32: old CSR value (combinational).
- `ex_pc` in 32: PC of the instruction in execute.
- `retire` in 1: one instruction retires this cycle.
- `mret` in 1: mret in execute.
- `wfi` in 1: wfi in execute.
- `irq_mei`, `irq_msi`, `irq_mti` in 1: level interrupt lines.
- `irq_local` in NUM_LOCAL: level platform lines.
- `redirect` out 1: take `redirect_pc` this cycle.
- `redirect_pc` out 32: trap target or mepc.
- `sleep` out 1: core is halted in WFI.
- `irq_active` out 1: mstatus.MIE; also exported for debug.

## Operation
- Implemented CSRs: mstatus (MIE b3, MPIE b7, MPP b12:11 hardwired 2'b11), mie, mip (read-only, live lines), mtvec, mepc (bits 1:0 read 0), mcause, mscratch, mcycle/h, minstret/h. All other addresses read 0; writes to them are ignored.
- Write source: rs1_data for ops 001-011, zero-extended uimm for ops 101-111.
- RS/RC/RSI/RCI with a source index of 0 perform no write. RW/RWI always write.
- Writes commit at the clock edge when `csr_valid & ~stall & ~take`.
- Pending set is `P = mip & mie`.
- `take = mstatus.MIE & |P & ~stall`, with the core in RUN, or in SLEEP at wake.
- Priority: MEI(11) > MSI(3) > MTI(7) > local lowest index first (code 16+i).
- Trap entry, committed at the edge:
  - mepc = ex_pc, or wfi_pc+4 if waking from SLEEP.
  - mcause = {1'b1, 26'b0, code}.
  - MPIE = MIE, MIE = 0.
- mret (when `~take`): MIE = MPIE, MPIE = 1, `redirect_pc` = mepc.
- redirect_pc on trap:
  - mtvec[1:0]==01 (vectored): {mtvec[31:2],2'b00} + 4*code.
  - otherwise: {mtvec[31:2],2'b00}.
- mcycle increments every cycle. minstret increments on `retire & ~stall`. A CSR write to either counter half wins over the increment in that cycle; the other half is untouched.
- WFI FSM, two states:
  - RUN -> SLEEP on `wfi & ~stall & ~|P`, capturing wfi_pc = ex_pc.
  - `wfi` with `|P` already set is a NOP.
  - SLEEP -> RUN when `|P`, regardless of MIE. If MIE=1 the trap is taken in the same cycle; otherwise execution resumes at wfi_pc+4 (`redirect`=1).
  - `sleep` = state==SLEEP.
- Simultaneous events: trap beats CSR write and beats mret; the suppressed instruction re-executes after the handler.

## Timing
- `csr_rdata`, `redirect`, `redirect_pc`: combinational from the current state. New CSR values are visible the cycle after the write edge.
- Trap latency: an enabled line asserted at cycle N gives `redirect`=1 in cycle N (if not stalled), with mepc/mcause updated at the edge ending cycle N.
- Reset values:
  - All CSRs 0, except mtvec = MTVEC_RST and MPP = 2'b11.
  - minstret = 0; FSM = RUN.
  - `redirect`=0, `sleep`=0, `irq_active`=0, `redirect_pc`=0.
- Reset mid-sleep returns to RUN immediately (asynchronous).
- Counters wrap 2^64-1 -> 0.

## Configuration
- `CSR_VECTORED_EN` defined: mtvec[1:0] is writable with values 00/01; value 01 selects vectored dispatch.
- Not defined: mtvec[1:0] is hardwired to 00, writes to those bits are ignored, and all traps go to the base address.

## Structure
- `csr_pkg`:
  - CSR address localparams.
  - funct3 enum.
  - cause-code constants (MEI=11, MSI=3, MTI=7, LOCAL_BASE=16).
  - `wfi_state_t` {RUN, SLEEP}.
- Sub-module `csr_irq_arbiter`: takes P (16+NUM_LOCAL bits) and outputs `any`, `code[4:0]`.

## Test plan
- CSRRW mtvec=0x1000, mie=0x800, CSRRSI mstatus uimm=8; pulse irq_mei at ex_pc=0x200 -> redirect_pc=0x1000, then mcause=0x8000000B, mepc=0x200, MIE=0, MPIE=1.
- With CSR_VECTORED_EN, mtvec=0x1001, mie bit 17 set, irq_local[1]=1 -> redirect_pc=0x1000+4*17=0x1044.
- irq_mei and irq_mti both set and both enabled -> code 11; deassert mei -> after mret, code 7 is taken.
- WFI at 0x300 with P=0 -> sleep=1. Assert irq_mti with MIE=0 -> sleep=0, redirect_pc=0x304, mcause unchanged.
- CSRRS mstatus with rs1_idx=0 while MIE=1 -> no change and rdata=0x1888; CSRRC with rs1=x5 holding 8 -> MIE cleared.
- Write mcycle=0xFFFF_FFFF, then next cycle mcycleh increments by 1. Write minstret=5 while retire=1 -> minstret reads 5.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and interrupt controller:
// CSR addresses, Zicsr op encodings, cause codes and the WFI state type.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [2:0] {
    F3_RW  = 3'b001,
    F3_RS  = 3'b010,
    F3_RC  = 3'b011,
    F3_RWI = 3'b101,
    F3_RSI = 3'b110,
    F3_RCI = 3'b111
  } csr_funct3_t;

  localparam logic [4:0] CAUSE_MEI        = 5'd11;
  localparam logic [4:0] CAUSE_MSI        = 5'd3;
  localparam logic [4:0] CAUSE_MTI        = 5'd7;
  localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

  typedef enum logic {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } wfi_state_t;

  // op is funct3[1:0]: 01 write, 10 set bits, 11 clear bits.
  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] src);
    logic [31:0] res;
    case (op)
      2'b01:   res = src;
      2'b10:   res = old | src;
      2'b11:   res = old & ~src;
      default: res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt arbiter: MEI > MSI > MTI > platform lines,
// lowest platform index first.
module csr_irq_arbiter
  import csr_pkg::*;
#(
  parameter int NUM_LOCAL = 4
) (
  input  logic [16+NUM_LOCAL-1:0] pend,
  output logic                    any,
  output logic [4:0]              code
);

  always_comb begin
    any  = |pend;
    code = '0;
    // Walk from lowest to highest priority so the last hit wins.
    for (int i = NUM_LOCAL - 1; i >= 0; i--) begin
      if (pend[16+i]) code = CAUSE_LOCAL_BASE + 5'(i);
    end
    if (pend[CAUSE_MTI]) code = CAUSE_MTI;
    if (pend[CAUSE_MSI]) code = CAUSE_MSI;
    if (pend[CAUSE_MEI]) code = CAUSE_MEI;
  end

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file, counters, interrupt controller and WFI sleep FSM.
// Define CSR_VECTORED_EN to make mtvec[1:0] writable and enable vectored dispatch.
module csr_irq_unit
  import csr_pkg::*;
#(
  parameter int          NUM_LOCAL = 4,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0288
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 csr_valid,
  input  logic [11:0]          csr_addr,
  input  logic [2:0]           csr_funct3,
  input  logic [4:0]           csr_rs1_idx,
  input  logic [31:0]          csr_rs1_data,
  output logic [31:0]          csr_rdata,
  input  logic [31:0]          ex_pc,
  input  logic                 retire,
  input  logic                 mret,
  input  logic                 wfi,
  input  logic                 irq_mei,
  input  logic                 irq_msi,
  input  logic                 irq_mti,
  input  logic [NUM_LOCAL-1:0] irq_local,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic                 sleep,
  output logic                 irq_active
);

  localparam int PW = 16 + NUM_LOCAL;

`ifdef CSR_VECTORED_EN
  localparam logic [31:0] MTVEC_INIT = {MTVEC_RST[31:2], 1'b0, MTVEC_RST[0]};
`else
  localparam logic [31:0] MTVEC_INIT = {MTVEC_RST[31:2], 2'b00};
`endif

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mscratch;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic [31:0] wfi_pc;
  wfi_state_t  state;

  logic [31:0] mip_live;
  logic [31:0] mstatus_rd;
  logic [PW-1:0] pend;
  logic        irq_any;
  logic [4:0]  irq_code;

  always_comb begin
    mip_live = '0;
    mip_live[CAUSE_MSI] = irq_msi;
    mip_live[CAUSE_MTI] = irq_mti;
    mip_live[CAUSE_MEI] = irq_mei;
    for (int i = 0; i < NUM_LOCAL; i++) mip_live[16+i] = irq_local[i];
  end

  assign pend = mip_live[PW-1:0] & mie[PW-1:0];

  csr_irq_arbiter #(
    .NUM_LOCAL(NUM_LOCAL)
  ) u_arb (
    .pend(pend),
    .any (irq_any),
    .code(irq_code)
  );

  // Event decode: a trap pre-empts any CSR write or mret in the same cycle.
  logic        take;
  logic        wake;
  logic        resume;
  logic        mret_do;
  logic        go_sleep;
  logic        in_run;

  assign in_run   = (state == RUN);
  assign take     = mstatus_mie & irq_any & ~stall;
  assign wake     = ~in_run & irq_any & ~stall;
  assign resume   = wake & ~mstatus_mie;
  assign mret_do  = mret & ~stall & ~take & in_run;
  assign go_sleep = in_run & wfi & ~stall & ~irq_any;

  logic [31:0] trap_base;
  logic [31:0] trap_pc;
  logic [31:0] trap_epc;
  logic [31:0] resume_pc;

  assign trap_base = {mtvec[31:2], 2'b00};
  assign trap_pc   = (mtvec[1:0] == 2'b01) ? trap_base + {25'b0, irq_code, 2'b00}
                                           : trap_base;
  assign resume_pc = wfi_pc + 32'd4;
  assign trap_epc  = in_run ? ex_pc : resume_pc;

  always_comb begin
    redirect    = take | resume | mret_do;
    redirect_pc = '0;
    if (take)         redirect_pc = trap_pc;
    else if (resume)  redirect_pc = resume_pc;
    else if (mret_do) redirect_pc = mepc;
  end

  assign sleep      = ~in_run;
  assign irq_active = mstatus_mie;

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_rd;
      CSR_MIE:       csr_rdata = mie;
      CSR_MIP:       csr_rdata = mip_live;
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MSCRATCH:  csr_rdata = mscratch;
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      default:       csr_rdata = '0;
    endcase
  end

  // Zicsr write path: set/clear forms with a zero source index do not write.
  logic [31:0] wr_src;
  logic [31:0] wr_data;
  logic        wr_en;

  assign wr_src  = csr_funct3[2] ? {27'b0, csr_rs1_idx} : csr_rs1_data;
  assign wr_data = csr_apply(csr_funct3[1:0], csr_rdata, wr_src);
  assign wr_en   = csr_valid & ~stall & ~take & in_run &
                   (csr_funct3[1:0] != 2'b00) &
                   (~csr_funct3[1] | (csr_rs1_idx != 5'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie          <= '0;
      mtvec        <= MTVEC_INIT;
      mepc         <= '0;
      mcause       <= '0;
      mscratch     <= '0;
    end else begin
      if (wr_en) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            mstatus_mie  <= wr_data[3];
            mstatus_mpie <= wr_data[7];
          end
          CSR_MIE:      mie      <= wr_data;
`ifdef CSR_VECTORED_EN
          CSR_MTVEC:    mtvec    <= {wr_data[31:2], 1'b0, wr_data[0]};
`else
          CSR_MTVEC:    mtvec    <= {wr_data[31:2], 2'b00};
`endif
          CSR_MEPC:     mepc     <= {wr_data[31:2], 2'b00};
          CSR_MCAUSE:   mcause   <= wr_data;
          CSR_MSCRATCH: mscratch <= wr_data;
          default: ;
        endcase
      end
      if (take) begin
        mepc         <= {trap_epc[31:2], 2'b00};
        mcause       <= {1'b1, 26'b0, irq_code};
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret_do) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  // Counters: a write to one half replaces that half and freezes the other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_en && csr_addr == CSR_MCYCLE)
        mcycle <= {mcycle[63:32], wr_data};
      else if (wr_en && csr_addr == CSR_MCYCLEH)
        mcycle <= {wr_data, mcycle[31:0]};
      else
        mcycle <= mcycle + 64'd1;

      if (wr_en && csr_addr == CSR_MINSTRET)
        minstret <= {minstret[63:32], wr_data};
      else if (wr_en && csr_addr == CSR_MINSTRETH)
        minstret <= {wr_data, minstret[31:0]};
      else if (retire && !stall)
        minstret <= minstret + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      wfi_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (go_sleep) begin
            state  <= SLEEP;
            wfi_pc <= ex_pc;
          end
        end
        SLEEP: begin
          if (wake) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed and randomized bench for csr_irq_unit, checked cycle by cycle
// against a behavioural model of the CSR file and interrupt rules.
module tb_csr_irq_unit;
  import csr_pkg::*;

  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          csr_valid;
  logic [11:0]   csr_addr;
  logic [2:0]    csr_funct3;
  logic [4:0]    csr_rs1_idx;
  logic [31:0]   csr_rs1_data;
  logic [31:0]   csr_rdata;
  logic [31:0]   ex_pc;
  logic          retire;
  logic          mret;
  logic          wfi;
  logic          irq_mei;
  logic          irq_msi;
  logic          irq_mti;
  logic [NL-1:0] irq_local;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          sleep;
  logic          irq_active;

  csr_irq_unit #(
    .NUM_LOCAL(NL),
    .MTVEC_RST(32'h0000_0288)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .csr_valid(csr_valid),
    .csr_addr(csr_addr), .csr_funct3(csr_funct3), .csr_rs1_idx(csr_rs1_idx),
    .csr_rs1_data(csr_rs1_data), .csr_rdata(csr_rdata), .ex_pc(ex_pc),
    .retire(retire), .mret(mret), .wfi(wfi), .irq_mei(irq_mei),
    .irq_msi(irq_msi), .irq_mti(irq_mti), .irq_local(irq_local),
    .redirect(redirect), .redirect_pc(redirect_pc), .sleep(sleep),
    .irq_active(irq_active)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0]       m_mie, m_mtvec, m_mepc, m_mcause, m_mscratch, m_wfi_pc;
  bit              m_ie, m_pie, m_asleep;
  longint unsigned m_cycle, m_instret;
  int              prio[$];

  task automatic m_reset();
    m_mie = 0; m_mtvec = 32'h288; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
    m_wfi_pc = 0; m_ie = 0; m_pie = 0; m_asleep = 0; m_cycle = 0; m_instret = 0;
  endtask

  function automatic bit [31:0] m_lines();
    bit [31:0] l = 0;
    l[11] = irq_mei; l[3] = irq_msi; l[7] = irq_mti;
    for (int i = 0; i < NL; i++) l[16+i] = irq_local[i];
    return l;
  endfunction

  function automatic int m_code(input bit [31:0] p);
    foreach (prio[k]) if (p[prio[k]]) return prio[k];
    return -1;
  endfunction

  function automatic bit [31:0] m_read(input bit [11:0] a);
    case (a)
      CSR_MSTATUS:   return 32'h1800 | (32'(m_pie) << 7) | (32'(m_ie) << 3);
      CSR_MIE:       return m_mie;
      CSR_MIP:       return m_lines();
      CSR_MTVEC:     return m_mtvec;
      CSR_MEPC:      return m_mepc;
      CSR_MCAUSE:    return m_mcause;
      CSR_MSCRATCH:  return m_mscratch;
      CSR_MCYCLE:    return m_cycle[31:0];
      CSR_MCYCLEH:   return m_cycle[63:32];
      CSR_MINSTRET:  return m_instret[31:0];
      CSR_MINSTRETH: return m_instret[63:32];
      default:       return 0;
    endcase
  endfunction

  task automatic m_eval(output bit tk, output bit rs, output bit mr, output bit [31:0] pc);
    bit [31:0] p = m_lines() & m_mie;
    bit [31:0] base = m_mtvec & ~32'h3;
    tk = m_ie && p != 0 && !stall;
    rs = m_asleep && p != 0 && !stall && !m_ie;
    mr = mret && !stall && !tk && !m_asleep;
    if (tk)      pc = (m_mtvec[1:0] == 2'b01) ? base + 32'(4 * m_code(p)) : base;
    else if (rs) pc = m_wfi_pc + 4;
    else if (mr) pc = m_mepc;
    else         pc = 0;
  endtask

  task automatic m_step();
    bit tk, rs, mr, was_asleep, wr;
    bit [31:0] pc, p, src, nv, old;
    longint unsigned c, ir;
    if (rst) begin
      m_reset();
      return;
    end
    m_eval(tk, rs, mr, pc);
    p = m_lines() & m_mie;
    was_asleep = m_asleep;
    wr = csr_valid && !stall && !tk && !m_asleep && csr_funct3[1:0] != 2'b00 &&
         (!csr_funct3[1] || csr_rs1_idx != 0);
    src = csr_funct3[2] ? 32'(csr_rs1_idx) : csr_rs1_data;
    old = m_read(csr_addr);
    case (csr_funct3[1:0])
      2'b01:   nv = src;
      2'b10:   nv = old | src;
      default: nv = old & ~src;
    endcase
    c  = m_cycle + 1;
    ir = m_instret + ((retire && !stall) ? 1 : 0);
    if (wr) begin
      case (csr_addr)
        CSR_MSTATUS:   begin m_ie = nv[3]; m_pie = nv[7]; end
        CSR_MIE:       m_mie = nv;
`ifdef CSR_VECTORED_EN
        CSR_MTVEC:     m_mtvec = {nv[31:2], 1'b0, nv[0]};
`else
        CSR_MTVEC:     m_mtvec = nv & ~32'h3;
`endif
        CSR_MEPC:      m_mepc = nv & ~32'h3;
        CSR_MCAUSE:    m_mcause = nv;
        CSR_MSCRATCH:  m_mscratch = nv;
        CSR_MCYCLE:    c  = {m_cycle[63:32], nv};
        CSR_MCYCLEH:   c  = {nv, m_cycle[31:0]};
        CSR_MINSTRET:  ir = {m_instret[63:32], nv};
        CSR_MINSTRETH: ir = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle = c;
    m_instret = ir;
    if (tk) begin
      m_mepc   = (was_asleep ? m_wfi_pc + 4 : ex_pc) & ~32'h3;
      m_mcause = 32'h8000_0000 | 32'(m_code(p));
      m_pie    = m_ie;
      m_ie     = 0;
      m_asleep = 0;
    end else if (mr) begin
      m_ie  = m_pie;
      m_pie = 1;
    end
    if (rs) m_asleep = 0;
    if (!was_asleep && wfi && !stall && p == 0) begin
      m_asleep = 1;
      m_wfi_pc = ex_pc;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    bit tk, rs, mr;
    bit [31:0] pc;
    @(negedge clk);
    #1;
    m_eval(tk, rs, mr, pc);
    chk("rdata", 64'(csr_rdata), 64'(m_read(csr_addr)));
    chk("redirect", 64'(redirect), 64'(tk | rs | mr));
    chk("redirect_pc", 64'(redirect_pc), 64'(pc));
    chk("sleep", 64'(sleep), 64'(m_asleep));
    chk("irq_active", 64'(irq_active), 64'(m_ie));
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle();
    stall = 0; csr_valid = 0; csr_funct3 = 0; csr_rs1_idx = 0; csr_rs1_data = 0;
    retire = 0; mret = 0; wfi = 0;
  endtask

  task automatic csr_op(input bit [2:0] f3, input bit [11:0] a, input bit [4:0] idx,
                        input bit [31:0] d);
    csr_valid = 1; csr_funct3 = f3; csr_addr = a; csr_rs1_idx = idx; csr_rs1_data = d;
    tick();
    csr_valid = 0;
  endtask

  task automatic peek(input string tag, input bit [11:0] a, input bit [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, 64'(csr_rdata), 64'(exp));
  endtask

  logic [11:0] addrs [13] = '{CSR_MSTATUS, CSR_MIE, CSR_MIP, CSR_MTVEC, CSR_MEPC,
                              CSR_MCAUSE, CSR_MSCRATCH, CSR_MCYCLE, CSR_MCYCLEH,
                              CSR_MINSTRET, CSR_MINSTRETH, 12'h7C0, 12'h301};

  initial begin
    bit [31:0] hi0;
    prio = {11, 3, 7};
    for (int i = 0; i < NL; i++) prio.push_back(16 + i);
    idle();
    csr_addr = CSR_MTVEC; ex_pc = 0;
    irq_mei = 0; irq_msi = 0; irq_mti = 0; irq_local = '0;
    rst = 1;
    m_reset();
    repeat (2) tick();
    chk("rst_redirect_pc", 64'(redirect_pc), 64'h0);
    chk("rst_sleep", 64'(sleep), 64'h0);
    rst = 0;
    peek("rst_mtvec", CSR_MTVEC, 32'h288);

    // Basic external interrupt trap.
    csr_op(F3_RW, CSR_MTVEC, 5'd1, 32'h1000);
    csr_op(F3_RW, CSR_MIE, 5'd1, 32'h800);
    csr_op(F3_RSI, CSR_MSTATUS, 5'd8, 32'h0);
    ex_pc = 32'h200; irq_mei = 1;
    #1;
    chk("mei_redirect", 64'(redirect), 64'h1);
    chk("mei_pc", 64'(redirect_pc), 64'h1000);
    tick();
    irq_mei = 0;
    peek("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
    peek("mei_mepc", CSR_MEPC, 32'h200);
    peek("mei_mstatus", CSR_MSTATUS, 32'h1880);
    chk("mei_irq_active", 64'(irq_active), 64'h0);

    // Priority: MEI over MTI, then MTI once MEI drops.
    irq_mei = 1; irq_mti = 1;
    csr_op(F3_RW, CSR_MIE, 5'd1, 32'h880);
    mret = 1;
    #1;
    chk("mret_pc", 64'(redirect_pc), 64'h200);
    tick();
    mret = 0;
    tick();
    peek("prio_mei", CSR_MCAUSE, 32'h8000_000B);
    irq_mei = 0; mret = 1;
    tick();
    mret = 0;
    tick();
    peek("prio_mti", CSR_MCAUSE, 32'h8000_0007);
    irq_mti = 0;

    // WFI with MIE=0: wake resumes after the wfi.
    ex_pc = 32'h300; wfi = 1;
    tick();
    wfi = 0;
    chk("wfi_sleep", 64'(sleep), 64'h1);
    repeat (2) tick();
    irq_mti = 1;
    #1;
    chk("wake_redirect", 64'(redirect), 64'h1);
    chk("wake_pc", 64'(redirect_pc), 64'h304);
    tick();
    chk("wake_sleep", 64'(sleep), 64'h0);
    peek("wake_mcause", CSR_MCAUSE, 32'h8000_0007);
    irq_mti = 0;

    // Set with x0 does not write; clear with a register does.
    mret = 1;
    tick();
    mret = 0;
    csr_valid = 1; csr_funct3 = F3_RS; csr_addr = CSR_MSTATUS;
    csr_rs1_idx = 0; csr_rs1_data = 32'hFFFF_FFFF;
    #1;
    chk("rs_x0_rdata", 64'(csr_rdata), 64'h1888);
    tick();
    csr_valid = 0;
    peek("rs_x0_after", CSR_MSTATUS, 32'h1888);
    csr_op(F3_RC, CSR_MSTATUS, 5'd5, 32'h8);
    peek("rc_mstatus", CSR_MSTATUS, 32'h1880);
    chk("rc_irq_active", 64'(irq_active), 64'h0);

    // Counter carry and write-over-increment.
    csr_op(F3_RW, CSR_MCYCLE, 5'd1, 32'hFFFF_FFFF);
    peek("mcycle_lo", CSR_MCYCLE, 32'hFFFF_FFFF);
    hi0 = m_cycle[63:32];
    tick();
    peek("mcycleh_inc", CSR_MCYCLEH, hi0 + 1);
    peek("mcycle_wrap", CSR_MCYCLE, 32'h0);
    retire = 1;
    csr_op(F3_RW, CSR_MINSTRET, 5'd1, 32'h5);
    retire = 0;
    peek("minstret_wr", CSR_MINSTRET, 32'h5);

    // mtvec mode bits and local interrupt dispatch.
    csr_op(F3_RW, CSR_MTVEC, 5'd1, 32'h1003);
`ifdef CSR_VECTORED_EN
    peek("mtvec_mode", CSR_MTVEC, 32'h1001);
`else
    peek("mtvec_mode", CSR_MTVEC, 32'h1000);
`endif
    csr_op(F3_RW, CSR_MIE, 5'd1, 32'h0002_0000);
    csr_op(F3_RSI, CSR_MSTATUS, 5'd8, 32'h0);
    irq_local = 4'b0010;
    #1;
`ifdef CSR_VECTORED_EN
    chk("local_pc", 64'(redirect_pc), 64'h1044);
`else
    chk("local_pc", 64'(redirect_pc), 64'h1000);
`endif
    tick();
    irq_local = '0;
    peek("local_mcause", CSR_MCAUSE, 32'h8000_0011);

    // Unimplemented address and live mip.
    csr_op(F3_RW, 12'h7C0, 5'd1, 32'h1234);
    peek("unimpl", 12'h7C0, 32'h0);
    irq_msi = 1;
    peek("mip_msi", CSR_MIP, 32'h8);
    irq_msi = 0;

    // Asynchronous reset while asleep.
    ex_pc = 32'h400; wfi = 1;
    tick();
    wfi = 0;
    chk("sleep2", 64'(sleep), 64'h1);
    #2;
    rst = 1;
    m_reset();
    #1;
    chk("rst_async_sleep", 64'(sleep), 64'h0);
    peek("rst_async_mtvec", CSR_MTVEC, 32'h288);
    tick();
    rst = 0;
    tick();

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      int k = $urandom_range(0, 15);
      stall     = ($urandom_range(0, 4) == 0);
      retire    = 1'($urandom_range(0, 1));
      csr_valid = (k < 6);
      mret      = (k == 6);
      wfi       = (k == 7);
      csr_addr  = addrs[$urandom_range(0, 12)];
      csr_funct3   = 3'($urandom_range(0, 7));
      csr_rs1_idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      csr_rs1_data = $urandom;
      ex_pc        = $urandom & ~32'h3;
      if ($urandom_range(0, 7) == 0) irq_mei = ~irq_mei;
      if ($urandom_range(0, 7) == 0) irq_msi = ~irq_msi;
      if ($urandom_range(0, 7) == 0) irq_mti = ~irq_mti;
      if ($urandom_range(0, 7) == 0) irq_local = NL'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
